snake_tick_gen: RTL and testbench
=================================

# snake_tick_gen

Parametrised game-tick generator for the snake datapath. It divides `clk` down to a one-cycle `tick` pulse. The tick period starts at a configurable base value and shortens by a fixed step on each `speed_up` request, saturating at a minimum period. It also keeps a wrapping count of issued ticks for the score/HEX display path. It replaces the fixed four-rate divider and the separate 4-bit display counter with one block.

## Interface
Parameters:
- `CNT_W`, 28: width of the period and down-counter registers.
- `BASE_PERIOD`, 50_000_000: period in clk cycles after `clear`; 1 s at 50 MHz.
- `MIN_PERIOD`, 5_000_000: lowest reachable period; must be ≥ 1.
- `STEP`, 2_500_000: amount subtracted from the period per `speed_up`.
- `TICK_CNT_W`, 8: width of `tick_count`.
- Legal values: 1 ≤ MIN_PERIOD ≤ BASE_PERIOD ≤ 2^CNT_W − 1 and STEP ≥ 1.

Ports:
- `clk`, in, 1: single clock, CLOCK_50 at top level.
- `clear`, in, 1: reset; synchronous, active-high.
- `enable`, in, 1: run the counter; when low, all counting state holds.
- `speed_up`, in, 1: one-cycle request to shorten the period by STEP.
- `tick`, out, 1: registered one-cycle pulse, once per period.
- `period`, out, CNT_W: current reload period.
- `tick_count`, out, TICK_CNT_W: number of ticks issued, modulo 2^TICK_CNT_W.
- `at_max_speed`, out, 1: high when `period == MIN_PERIOD`.

## Operation
- Registers: `count` (CNT_W), `period` (CNT_W), `tick` (1), `tick_count` (TICK_CNT_W).
- Every edge with `clear`=1: `count`←0, `period`←BASE_PERIOD, `tick`←0, `tick_count`←0.
  - `clear` overrides `enable` and `speed_up` in the same cycle.
- Edge with `enable`=1 and `count`==0 (reload):
  - `count`←`period`−1, `tick`←1, `tick_count`←`tick_count`+1.
  - `tick_count` wraps from all-ones to 0 with no flag.
- Edge with `enable`=1 and `count`≠0: `count`←`count`−1, `tick`←0.
- Edge with `enable`=0: `count` and `tick_count` hold, `tick`←0.
  - A tick is never lost or duplicated across an enable gap; it is only delayed.
- `speed_up` is sampled on every non-clear edge, regardless of `enable`:
  - If `period` ≥ MIN_PERIOD+STEP: `period`←`period`−STEP.
  - Otherwise: `period`←MIN_PERIOD (saturate).
  - Do the comparison at CNT_W+1 bits so MIN_PERIOD+STEP cannot overflow and `period`−STEP cannot underflow.
- A new `period` does not truncate the running count. It applies at the next reload.
  - If `speed_up` and a reload happen on the same edge, the reload uses the old `period`.
- `speed_up` held high for N cycles counts as N requests.
- `at_max_speed` is combinational from the `period` register.

## Timing
- Reset values: `tick`=0, `tick_count`=0, `period`=BASE_PERIOD, `at_max_speed`=(BASE_PERIOD==MIN_PERIOD).
- With `enable` continuously high after `clear` drops:
  - The first `tick` goes high on the first edge after `clear` deasserts.
  - Later ticks are exactly `period` cycles apart.
- `tick` is high for exactly one cycle per reload.
  - With `period`=1, `tick` stays high every cycle.
- `tick_count` and `tick` update on the same edge.
- `period` updates one edge after a `speed_up` sample; `at_max_speed` follows in the same cycle.
- `clear` mid-count: on the next edge the block is in full reset state. Any in-flight tick is discarded.

## Test plan
All scenarios use CNT_W=8, BASE_PERIOD=10, MIN_PERIOD=3, STEP=3, TICK_CNT_W=4.
- Hold `enable`=1 after `clear`, run 40 cycles → `tick` at relative cycles 1, 11, 21, 31; `tick_count` reads 1, 2, 3, 4 after each tick.
- Pulse `speed_up` once at relative cycle 5 → `period`=7 at cycle 6; next tick still at cycle 11; following ticks at 18 and 25.
- Pulse `speed_up` four times → `period` goes 10→7→4→3→3; `at_max_speed`=1 after the third pulse; the fourth pulse leaves `period`=3.
- Drop `enable` for 4 cycles mid-count (cycles 14–17) → next tick moves from 21 to 25; no extra ticks; `tick_count` unchanged during the gap.
- Issue 16 ticks → `tick_count` goes 15→0 on the 16th tick; `tick` is still pulsed.
- Assert `clear`, `enable` and `speed_up` together mid-count with `period`=4 → next cycle `period`=10, `tick`=0, `tick_count`=0, `at_max_speed`=0; after `clear` drops, first tick comes on the next edge.

Source files
------------

// File: rtl/snake_tick_gen.sv
// rtl/snake_tick_gen.sv - game-tick divider with stepwise speed-up and wrapping tick counter
module snake_tick_gen #(
    parameter int CNT_W       = 28,
    parameter int BASE_PERIOD = 50_000_000,
    parameter int MIN_PERIOD  = 5_000_000,
    parameter int STEP        = 2_500_000,
    parameter int TICK_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  speed_up,
    output logic                  tick,
    output logic [CNT_W-1:0]      period,
    output logic [TICK_CNT_W-1:0] tick_count,
    output logic                  at_max_speed
);

    localparam logic [CNT_W-1:0] BASE_P  = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W:0]   MIN_EXT = (CNT_W+1)'(MIN_PERIOD);
    localparam logic [CNT_W:0]   STEP_EXT = (CNT_W+1)'(STEP);

    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   period_ext;
    logic [CNT_W:0]   period_dec;
    logic [CNT_W-1:0] period_next;

    // Extra bit keeps MIN+STEP from overflowing and period-STEP from wrapping.
    always_comb begin
        period_ext  = {1'b0, period};
        period_dec  = period_ext - STEP_EXT;
        period_next = period;
        if (speed_up) begin
            if (period_ext >= (MIN_EXT + STEP_EXT)) begin
                period_next = period_dec[CNT_W-1:0];
            end else begin
                period_next = MIN_P;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count      <= '0;
            period     <= BASE_P;
            tick       <= 1'b0;
            tick_count <= '0;
        end else begin
            period <= period_next;
            if (enable) begin
                if (count == '0) begin
                    // Reload samples the pre-speed-up period; a new period waits for the next reload.
                    count      <= period - CNT_W'(1);
                    tick       <= 1'b1;
                    tick_count <= tick_count + TICK_CNT_W'(1);
                end else begin
                    count <= count - CNT_W'(1);
                    tick  <= 1'b0;
                end
            end else begin
                tick <= 1'b0;
            end
        end
    end

    assign at_max_speed = (period == MIN_P);

endmodule

// File: tb/tb_snake_tick_gen.sv
// tb/tb_snake_tick_gen.sv - self-checking bench for snake_tick_gen with a tick-interval reference model
module tb_snake_tick_gen;

    localparam int CNT_W = 8;
    localparam int BASE  = 10;
    localparam int MINP  = 3;
    localparam int STEP  = 3;
    localparam int TCW   = 4;

    logic             clk;
    logic             clear;
    logic             enable;
    logic             speed_up;
    logic             tick;
    logic [CNT_W-1:0] period;
    logic [TCW-1:0]   tick_count;
    logic             at_max_speed;

    int checks   = 0;
    int failures = 0;

    // Reference model: ticks are spaced by the period in force at the previous tick,
    // counted in enabled edges only; the first enabled edge after clear ticks.
    int m_period;
    int m_gap;
    int m_elapsed;
    int m_cnt;
    bit m_tick;
    int rel;

    snake_tick_gen #(
        .CNT_W(CNT_W), .BASE_PERIOD(BASE), .MIN_PERIOD(MINP), .STEP(STEP), .TICK_CNT_W(TCW)
    ) dut (
        .clk(clk), .clear(clear), .enable(enable), .speed_up(speed_up),
        .tick(tick), .period(period), .tick_count(tick_count), .at_max_speed(at_max_speed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic edge_step();
        int old_period;
        @(posedge clk);
        if (clear) begin
            m_period = BASE; m_gap = 1; m_elapsed = 0; m_tick = 0; m_cnt = 0; rel = 0;
        end else begin
            rel++;
            old_period = m_period;
            if (speed_up) m_period = (m_period - STEP > MINP) ? m_period - STEP : MINP;
            m_tick = 0;
            if (enable) begin
                m_elapsed++;
                if (m_elapsed >= m_gap) begin
                    m_tick = 1; m_cnt = (m_cnt + 1) % (1 << TCW);
                    m_gap = old_period; m_elapsed = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1; enable = 0; speed_up = 0;
        edge_step();
        clear = 0;
    endtask

    task automatic test_reset();
        clear = 1; enable = 1; speed_up = 1;
        edge_step();
        edge_step();
        checks++;
        if (tick !== 1'b0 || tick_count !== 4'd0 || period !== 8'd10 || at_max_speed !== 1'b0) begin
            failures++;
            $display("FAIL reset tick=%0b cnt=%0d period=%0d max=%0b exp 0/0/10/0",
                     tick, tick_count, period, at_max_speed);
        end
        clear = 0; speed_up = 0;
    endtask

    task automatic test_free_run();
        int exp_ticks[4] = '{1, 11, 21, 31};
        int n = 0;
        bit exp_t;
        do_clear();
        enable = 1;
        for (int r = 1; r <= 40; r++) begin
            edge_step();
            exp_t = (n < 4) && (exp_ticks[n] == r);
            if (exp_t) n++;
            checks++;
            if (tick !== exp_t || tick_count !== TCW'(n)) begin
                failures++;
                $display("FAIL free_run rel=%0d tick=%0b cnt=%0d exp tick=%0b cnt=%0d",
                         r, tick, tick_count, exp_t, n);
            end
        end
    endtask

    task automatic test_speed_up();
        int exp_ticks[4] = '{1, 11, 18, 25};
        int n = 0;
        bit exp_t;
        do_clear();
        enable = 1;
        for (int r = 1; r <= 30; r++) begin
            speed_up = (r == 5);
            edge_step();
            exp_t = (n < 4) && (exp_ticks[n] == r);
            if (exp_t) n++;
            checks++;
            if (tick !== exp_t || tick_count !== TCW'(n)) begin
                failures++;
                $display("FAIL speed_up_tick rel=%0d tick=%0b cnt=%0d exp tick=%0b cnt=%0d",
                         r, tick, tick_count, exp_t, n);
            end
            if (r == 5) begin
                checks++;
                if (period !== 8'd7) begin
                    failures++;
                    $display("FAIL speed_up_period got=%0d exp=7", period);
                end
            end
        end
        speed_up = 0;
    endtask

    task automatic test_max_speed();
        int exp_p[4] = '{7, 4, 3, 3};
        bit exp_m[4] = '{0, 0, 1, 1};
        do_clear();
        for (int i = 0; i < 4; i++) begin
            speed_up = 1;
            edge_step();
            speed_up = 0;
            checks++;
            if (period !== CNT_W'(exp_p[i]) || at_max_speed !== exp_m[i]) begin
                failures++;
                $display("FAIL max_speed pulse=%0d period=%0d max=%0b exp %0d/%0b",
                         i + 1, period, at_max_speed, exp_p[i], exp_m[i]);
            end
            edge_step();
        end
    endtask

    task automatic test_enable_gap();
        int exp_ticks[3] = '{1, 11, 25};
        int n = 0;
        bit exp_t;
        do_clear();
        for (int r = 1; r <= 30; r++) begin
            enable = !(r >= 14 && r <= 17);
            edge_step();
            exp_t = (n < 3) && (exp_ticks[n] == r);
            if (exp_t) n++;
            checks++;
            if (tick !== exp_t || tick_count !== TCW'(n)) begin
                failures++;
                $display("FAIL enable_gap rel=%0d tick=%0b cnt=%0d exp tick=%0b cnt=%0d",
                         r, tick, tick_count, exp_t, n);
            end
        end
        enable = 1;
    endtask

    task automatic test_wrap();
        int seen = 0;
        do_clear();
        for (int i = 0; i < 3; i++) begin
            speed_up = 1; edge_step();
        end
        speed_up = 0;
        enable = 1;
        for (int c = 0; c < 100 && seen < 16; c++) begin
            edge_step();
            if (tick === 1'b1) begin
                seen++;
                checks++;
                if (tick_count !== TCW'(seen % 16)) begin
                    failures++;
                    $display("FAIL wrap tick#%0d cnt=%0d exp=%0d", seen, tick_count, seen % 16);
                end
            end
        end
        checks++;
        if (seen != 16 || tick_count !== 4'd0) begin
            failures++;
            $display("FAIL wrap_final ticks=%0d cnt=%0d exp 16/0", seen, tick_count);
        end
    endtask

    task automatic test_clear_override();
        do_clear();
        speed_up = 1; edge_step(); edge_step();
        speed_up = 0;
        enable = 1;
        for (int i = 0; i < 7; i++) edge_step();
        clear = 1; enable = 1; speed_up = 1;
        edge_step();
        checks++;
        if (period !== 8'd10 || tick !== 1'b0 || tick_count !== 4'd0 || at_max_speed !== 1'b0) begin
            failures++;
            $display("FAIL clear_override period=%0d tick=%0b cnt=%0d max=%0b exp 10/0/0/0",
                     period, tick, tick_count, at_max_speed);
        end
        clear = 0; speed_up = 0;
        edge_step();
        checks++;
        if (tick !== 1'b1 || tick_count !== 4'd1) begin
            failures++;
            $display("FAIL clear_restart tick=%0b cnt=%0d exp 1/1", tick, tick_count);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            clear    = ($urandom_range(0, 63) == 0);
            enable   = ($urandom_range(0, 3) != 0);
            speed_up = ($urandom_range(0, 7) == 0);
            edge_step();
            checks++;
            if (tick !== m_tick || period !== CNT_W'(m_period) || tick_count !== TCW'(m_cnt)
                || at_max_speed !== (m_period == MINP)) begin
                failures++;
                $display("FAIL random c=%0d tick=%0b period=%0d cnt=%0d max=%0b exp %0b/%0d/%0d/%0b",
                         c, tick, period, tick_count, at_max_speed,
                         m_tick, m_period, m_cnt, (m_period == MINP));
            end
        end
        clear = 0; speed_up = 0;
    endtask

    initial begin
        clear = 1; enable = 0; speed_up = 0;
        m_period = BASE; m_gap = 1; m_elapsed = 0; m_cnt = 0; m_tick = 0; rel = 0;
        @(negedge clk);
        test_reset();
        test_free_run();
        test_speed_up();
        test_max_speed();
        test_enable_gap();
        test_wrap();
        test_clear_override();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
